// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Sole driver of the register file write port. Merges unbuffered
//   single-cycle ALU results with load responses from data memory. Load
//   responses arrive at arbitrary times and are queued in a small FIFO.
//   The ALU has priority. A full FIFO takes the port for one cycle and
//   stalls the ALU for that cycle.
//
// Parameters
//   LOAD_DEPTH : load-response FIFO entries (power of two, >= 2)
//   XLEN       : data width
//
// Ports
//   clock, reset_n                : rising-edge clock, async active-low reset
//   alu_valid/alu_rd/alu_data     : ALU result presented this cycle
//   alu_stall                     : ALU result not taken; producer holds it
//   load_valid/load_rd/load_data  : load response from data memory
//   load_ready                    : FIFO can accept a load this cycle
//   pending                       : bit n set while a load to xn is queued
//   writeRegister/rd/dataToWrite  : registered register file write port

module regfile_writeback #(
  parameter int unsigned LOAD_DEPTH = 4,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_stall,
  input  logic            load_valid,
  input  logic [4:0]      load_rd,
  input  logic [XLEN-1:0] load_data,
  output logic            load_ready,
  output logic [31:0]     pending,
  output logic            writeRegister,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] dataToWrite
);

  localparam int unsigned PTR_W = $clog2(LOAD_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // FIFO storage and bookkeeping
  logic [4:0]            fifo_rd   [LOAD_DEPTH];
  logic [XLEN-1:0]       fifo_data [LOAD_DEPTH];
  logic [LOAD_DEPTH-1:0] slot_valid;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic alu_eff;
  logic fifo_grant;
  logic alu_grant;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(LOAD_DEPTH));

  // No bypass: an entry freed by this cycle's pop is usable only next cycle.
  assign load_ready = !fifo_full;

  // A load to x0 is accepted from the producer but never enqueued.
  assign push = load_valid && load_ready && (load_rd != 5'd0);

  // An ALU result to x0 counts as consumed and never competes for the port.
  assign alu_eff    = alu_valid && (alu_rd != 5'd0);
  assign fifo_grant = !fifo_empty && (!alu_eff || fifo_full);
  assign alu_grant  = alu_eff && !fifo_grant;
  assign alu_stall  = alu_eff && fifo_grant;
  assign pop        = fifo_grant;

  // Pending bitmap: OR of one-hot(rd) over every occupied slot, so duplicate
  // destinations keep their bit set until the last of them drains.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first;
    // a path that leaves it unassigned would infer a latch.
    pending = '0;
    for (int i = 0; i < int'(LOAD_DEPTH); i++) begin
      if (slot_valid[i]) pending[fifo_rd[i]] = 1'b1;
    end
  end

  // Pointers, count and occupancy flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values from before the edge.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      slot_valid <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // On a simultaneous push and pop the two slots differ: a pop needs
      // count > 0, a push needs count < LOAD_DEPTH, so wr_ptr != rd_ptr.
      if (pop)  slot_valid[rd_ptr] <= 1'b0;
      if (push) slot_valid[wr_ptr] <= 1'b1;
    end
  end

  // NOTE: the payload array has no reset. Slots are read only while their
  // slot_valid flag is set, and those flags are reset.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= load_rd;
      fifo_data[wr_ptr] <= load_data;
    end
  end

  // Registered write port. rd and dataToWrite hold their values when idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      writeRegister <= 1'b0;
      rd            <= '0;
      dataToWrite   <= '0;
    end else begin
      writeRegister <= fifo_grant || alu_grant;
      if (fifo_grant) begin
        rd          <= fifo_rd[rd_ptr];
        dataToWrite <= fifo_data[rd_ptr];
      end else if (alu_grant) begin
        rd          <= alu_rd;
        dataToWrite <= alu_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback.
// Each directed step pushes its hand-computed register file write into a
// queue. A monitor on the falling edge pops that queue and compares it
// every time writeRegister is high.

module tb_regfile_writeback;

  localparam int unsigned XLEN = 32;

  logic            clock;
  logic            reset_n;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_stall;
  logic            load_valid;
  logic [4:0]      load_rd;
  logic [XLEN-1:0] load_data;
  logic            load_ready;
  logic [31:0]     pending;
  logic            writeRegister;
  logic [4:0]      rd;
  logic [XLEN-1:0] dataToWrite;

  regfile_writeback #(.LOAD_DEPTH(4), .XLEN(XLEN)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .alu_stall     (alu_stall),
    .load_valid    (load_valid),
    .load_rd       (load_rd),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .pending       (pending),
    .writeRegister (writeRegister),
    .rd            (rd),
    .dataToWrite   (dataToWrite)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic expect_write(input logic [4:0] r, input logic [31:0] d);
    wb_t e;
    e.rd   = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ard,
                       input logic [31:0] ad, input logic lv,
                       input logic [4:0] lrd, input logic [31:0] ld);
    alu_valid  = av;
    alu_rd     = ard;
    alu_data   = ad;
    load_valid = lv;
    load_rd    = lrd;
    load_data  = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: compares every register file write against the queue head.
  always @(negedge clock) begin
    if (reset_n && writeRegister) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected none at %0t",
                 rd, dataToWrite, $time);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wb_rd", 32'(rd), 32'(e.rd));
        check("wb_data", dataToWrite, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    idle();
    #12;
    check("rst_we", 32'(writeRegister), 32'd0);
    check("rst_rd", 32'(rd), 32'd0);
    check("rst_data", dataToWrite, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_alu_stall", 32'(alu_stall), 32'd0);
    #10 reset_n = 1'b1;
    tick();

    // Reset mid-stream: queue loads x5..x7 behind ALU writes, then reset.
    drive(1'b1, 5'd1, 32'd1, 1'b1, 5'd5, 32'h55); expect_write(5'd1, 32'd1); tick();
    drive(1'b1, 5'd1, 32'd2, 1'b1, 5'd6, 32'h66); expect_write(5'd1, 32'd2); tick();
    drive(1'b1, 5'd1, 32'd3, 1'b1, 5'd7, 32'h77); expect_write(5'd1, 32'd3); tick();
    idle();
    #1 check("mid_pending_before", pending, 32'h0000_00E0);
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_pending", pending, 32'd0);
    check("mid_rst_we", 32'(writeRegister), 32'd0);
    check("mid_rst_load_ready", 32'(load_ready), 32'd1);
    #1 reset_n = 1'b1;
    repeat (4) tick();
    check("post_rst_pending", pending, 32'd0);

    // ALU only.
    drive(1'b1, 5'd10, 32'h4, 1'b0, 5'd0, 32'd0);
    expect_write(5'd10, 32'h4);
    #1 check("alu_only_stall", 32'(alu_stall), 32'd0);
    tick();
    idle();
    tick();

    // Load only.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hDEAD);
    expect_write(5'd11, 32'hDEAD);
    #1 check("load_only_ready", 32'(load_ready), 32'd1);
    tick();
    idle();
    #1 check("load_only_pending_set", pending, 32'h0000_0800);
    tick();
    check("load_only_pending_clr", pending, 32'd0);
    tick();

    // x0 handling: load to x0, then ALU to x0; neither may write.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    #1 check("x0_load_ready", 32'(load_ready), 32'd1);
    tick();
    drive(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'd0);
    #1 check("x0_alu_stall", 32'(alu_stall), 32'd0);
    check("x0_pending", pending, 32'd0);
    tick();
    idle();
    tick();
    check("x0_load_ready_after", 32'(load_ready), 32'd1);
    tick();

    // Duplicate destination: two loads to x9 (second push overlaps first pop).
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hA1);
    expect_write(5'd9, 32'hA1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hB2);
    expect_write(5'd9, 32'hB2);
    #1 check("dup_pending_1", pending, 32'h0000_0200);
    tick();
    idle();
    #1 check("dup_pending_2", pending, 32'h0000_0200);
    tick();
    check("dup_pending_clr", pending, 32'd0);
    tick();

    // Priority and starvation: continuous ALU writes to x1, loads x5..x8,
    // with an x0 load in between that must not occupy a slot.
    drive(1'b1, 5'd1, 32'd100, 1'b1, 5'd5, 32'h5); expect_write(5'd1, 32'd100);
    #1 check("prio_stall_c0", 32'(alu_stall), 32'd0);
    tick();
    drive(1'b1, 5'd1, 32'd101, 1'b1, 5'd6, 32'h6); expect_write(5'd1, 32'd101);
    tick();
    drive(1'b1, 5'd1, 32'd102, 1'b1, 5'd7, 32'h7); expect_write(5'd1, 32'd102);
    tick();
    drive(1'b1, 5'd1, 32'd103, 1'b1, 5'd0, 32'hBAD); expect_write(5'd1, 32'd103);
    #1 check("prio_stall_c3", 32'(alu_stall), 32'd0);
    tick();
    drive(1'b1, 5'd1, 32'd104, 1'b1, 5'd8, 32'h8); expect_write(5'd1, 32'd104);
    #1 check("prio_ready_c4", 32'(load_ready), 32'd1);
    tick();
    drive(1'b1, 5'd1, 32'd105, 1'b0, 5'd0, 32'd0); expect_write(5'd5, 32'h5);
    #1 check("prio_ready_full", 32'(load_ready), 32'd0);
    check("prio_stall_full", 32'(alu_stall), 32'd1);
    check("prio_pending_full", pending, 32'h0000_01E0);
    tick();
    // Stalled result is held and written this cycle.
    expect_write(5'd1, 32'd105);
    #1 check("prio_stall_after", 32'(alu_stall), 32'd0);
    check("prio_ready_after", 32'(load_ready), 32'd1);
    check("prio_pending_after", pending, 32'h0000_01C0);
    tick();
    idle();
    expect_write(5'd6, 32'h6);
    expect_write(5'd7, 32'h7);
    expect_write(5'd8, 32'h8);
    repeat (3) tick();
    check("prio_pending_drained", pending, 32'd0);

    repeat (3) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
